// File: rtl/mcpu_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS32 datapath.
// The sequencer is the master: it reads instruction fields and status and
// drives every datapath select and write-enable.
interface mcpu_sequencer_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       alu_zero;
  logic       mem_ready;

  logic       write_pc;
  logic       write_ir;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic [3:0] mem_mode;
  logic       sign_ext;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic       mem_to_reg;
  logic       retire;
  logic       halted;

  modport master (
    input  opcode, func, alu_zero, mem_ready,
    output write_pc, write_ir, pc_src, i_or_d, mem_mode, sign_ext,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
           retire, halted
  );

  modport slave (
    output opcode, func, alu_zero, mem_ready,
    input  write_pc, write_ir, pc_src, i_or_d, mem_mode, sign_ext,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
           retire, halted
  );
endinterface

// File: rtl/mcpu_sequencer.sv
// Moore control sequencer for the multi-cycle MIPS32 datapath.
// Holds in FETCH / MEM_RD / MEM_WR until the memory port acknowledges,
// and traps (until reset) on any undecodable instruction.
module mcpu_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  mcpu_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, LINK, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_PASS = 4'd12;

  localparam logic [3:0] MEM_IDLE  = 4'd0;
  localparam logic [3:0] MEM_READ  = 4'd1;
  localparam logic [3:0] MEM_WRITE = 4'd2;

  state_t state;
  state_t next_state;
  logic   func_legal;

  // R-type functs that the datapath can execute; anything else traps in DECODE
  always_comb begin
    case (bus.func)
      FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADDU, FN_SUBU, FN_AND, FN_OR,
      FN_XOR, FN_NOR, FN_SLT, FN_SLTU: func_legal = 1'b1;
      default:                         func_legal = 1'b0;
    endcase
  end

  // State register; reset forces IDLE, whose outputs are all zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and Moore outputs (FETCH/MEM_WR/BRANCH also look at live status)
  always_comb begin
    next_state     = state;
    bus.write_pc   = 1'b0;
    bus.write_ir   = 1'b0;
    bus.pc_src     = 2'd0;
    bus.i_or_d     = 1'b0;
    bus.mem_mode   = MEM_IDLE;
    bus.sign_ext   = 1'b0;
    bus.alu_src_a  = 2'd0;
    bus.alu_src_b  = 2'd0;
    bus.alu_op     = ALU_ADD;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 2'd0;
    bus.mem_to_reg = 1'b0;
    bus.retire     = 1'b0;
    bus.halted     = 1'b0;

    case (state)
      IDLE: next_state = FETCH;

      FETCH: begin
        bus.i_or_d    = 1'b0;
        bus.mem_mode  = MEM_READ;
        bus.alu_src_a = 2'd1;
        bus.alu_src_b = 2'd1;
        bus.alu_op    = ALU_ADD;
        bus.pc_src    = 2'd0;
        bus.write_ir  = bus.mem_ready;
        bus.write_pc  = bus.mem_ready;
        if (bus.mem_ready) next_state = DECODE;
      end

      DECODE: begin
        bus.alu_src_a = 2'd1;
        bus.alu_src_b = 2'd3;
        bus.sign_ext  = 1'b1;
        bus.alu_op    = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE:                 next_state = func_legal ? EXEC_R : TRAP;
          OP_J, OP_JAL:             next_state = JUMP;
          OP_BEQ, OP_BNE:           next_state = BRANCH;
          OP_ADDIU, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI:  next_state = EXEC_I;
          OP_LW, OP_SW:             next_state = MEM_ADDR;
          default:                  next_state = TRAP;
        endcase
      end

      EXEC_R: begin
        bus.alu_src_b = 2'd0;
        if (bus.func == FN_SLL || bus.func == FN_SRL || bus.func == FN_SRA)
          bus.alu_src_a = 2'd2;
        else
          bus.alu_src_a = 2'd0;
        case (bus.func)
          FN_SUBU: bus.alu_op = ALU_SUB;
          FN_AND:  bus.alu_op = ALU_AND;
          FN_OR:   bus.alu_op = ALU_OR;
          FN_XOR:  bus.alu_op = ALU_XOR;
          FN_NOR:  bus.alu_op = ALU_NOR;
          FN_SLT:  bus.alu_op = ALU_SLT;
          FN_SLTU: bus.alu_op = ALU_SLTU;
          FN_SLL:  bus.alu_op = ALU_SLL;
          FN_SRL:  bus.alu_op = ALU_SRL;
          FN_SRA:  bus.alu_op = ALU_SRA;
          FN_JR:   bus.alu_op = ALU_PASS;
          default: bus.alu_op = ALU_ADD;
        endcase
        if (bus.func == FN_JR) begin
          bus.pc_src   = 2'd0;
          bus.write_pc = 1'b1;
          bus.retire   = 1'b1;
          next_state   = FETCH;
        end else begin
          next_state   = WB_R;
        end
      end

      WB_R: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'd0;
        bus.mem_to_reg = 1'b0;
        bus.retire     = 1'b1;
        next_state     = FETCH;
      end

      EXEC_I: begin
        bus.alu_src_a = 2'd0;
        bus.alu_src_b = 2'd2;
        case (bus.opcode)
          OP_ADDIU: begin bus.alu_op = ALU_ADD; bus.sign_ext = 1'b1; end
          OP_SLTI:  begin bus.alu_op = ALU_SLT; bus.sign_ext = 1'b1; end
          OP_ANDI:  bus.alu_op = ALU_AND;
          OP_ORI:   bus.alu_op = ALU_OR;
          OP_XORI:  bus.alu_op = ALU_XOR;
          OP_LUI:   bus.alu_op = ALU_LUI;
          default:  bus.alu_op = ALU_ADD;
        endcase
        next_state = WB_I;
      end

      WB_I: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'd1;
        bus.retire    = 1'b1;
        next_state    = FETCH;
      end

      MEM_ADDR: begin
        bus.alu_src_a = 2'd0;
        bus.alu_src_b = 2'd2;
        bus.sign_ext  = 1'b1;
        bus.alu_op    = ALU_ADD;
        next_state    = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      end

      MEM_RD: begin
        bus.i_or_d   = 1'b1;
        bus.mem_mode = MEM_READ;
        if (bus.mem_ready) next_state = MEM_WB;
      end

      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'd1;
        bus.mem_to_reg = 1'b1;
        bus.retire     = 1'b1;
        next_state     = FETCH;
      end

      MEM_WR: begin
        bus.i_or_d   = 1'b1;
        bus.mem_mode = MEM_WRITE;
        bus.retire   = bus.mem_ready;
        if (bus.mem_ready) next_state = FETCH;
      end

      BRANCH: begin
        bus.alu_src_a = 2'd0;
        bus.alu_src_b = 2'd0;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = 2'd1;
        bus.retire    = 1'b1;
        bus.write_pc  = (bus.opcode == OP_BNE) ? ~bus.alu_zero : bus.alu_zero;
        next_state    = FETCH;
      end

      JUMP: begin
        bus.pc_src    = 2'd2;
        bus.write_pc  = 1'b1;
        bus.alu_src_a = 2'd1;
        bus.alu_op    = ALU_PASS;
        if (bus.opcode == OP_JAL) begin
          next_state = LINK;
        end else begin
          bus.retire = 1'b1;
          next_state = FETCH;
        end
      end

      LINK: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'd2;
        bus.mem_to_reg = 1'b0;
        bus.retire     = 1'b1;
        next_state     = FETCH;
      end

      TRAP: bus.halted = 1'b1;

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcpu_sequencer.sv
// Self-checking bench for mcpu_sequencer: a per-cycle vector table of
// instruction sequences plus hand-written reset and trap sequences.
// Outputs are packed as {write_pc, write_ir, pc_src, i_or_d, mem_mode,
// sign_ext, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
// retire, halted}.
module tb_mcpu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mcpu_sequencer_if bus ();

  mcpu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        az;
    logic        mr;
    logic [23:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] sb[$];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [23:0] mk(
    input logic wpc, input logic wir, input logic [1:0] pcs, input logic iod,
    input logic [3:0] mm, input logic se, input logic [1:0] asa,
    input logic [1:0] asb, input logic [3:0] aop, input logic rw,
    input logic [1:0] rd, input logic m2r, input logic ret, input logic hlt);
    return {wpc, wir, pcs, iod, mm, se, asa, asb, aop, rw, rd, m2r, ret, hlt};
  endfunction

  function automatic logic [23:0] e_fetch(input logic mr);
    return mk(mr, mr, 2'd0, 1'b0, 4'd1, 1'b0, 2'd1, 2'd1, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [23:0] e_decode();
    return mk(1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 2'd1, 2'd3, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [23:0] e_exec_r(input logic [1:0] asa, input logic [3:0] aop);
    return mk(1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, asa, 2'd0, aop, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [23:0] e_wb_r();
    return mk(1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [23:0] e_exec_i(input logic [3:0] aop, input logic se);
    return mk(1'b0, 1'b0, 2'd0, 1'b0, 4'd0, se, 2'd0, 2'd2, aop, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [23:0] e_wb_i();
    return mk(1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [23:0] e_mem_addr();
    return mk(1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 2'd0, 2'd2, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [23:0] e_mem_rd();
    return mk(1'b0, 1'b0, 2'd0, 1'b1, 4'd1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [23:0] e_mem_wb();
    return mk(1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [23:0] e_mem_wr(input logic mr);
    return mk(1'b0, 1'b0, 2'd0, 1'b1, 4'd2, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, mr, 1'b0);
  endfunction
  function automatic logic [23:0] e_branch(input logic wpc);
    return mk(wpc, 1'b0, 2'd1, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [23:0] e_jump(input logic ret);
    return mk(1'b1, 1'b0, 2'd2, 1'b0, 4'd0, 1'b0, 2'd1, 2'd0, 4'd12, 1'b0, 2'd0, 1'b0, ret, 1'b0);
  endfunction
  function automatic logic [23:0] e_link();
    return mk(1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
  endfunction
  localparam logic [23:0] E_ZERO = 24'h000000;
  localparam logic [23:0] E_TRAP = 24'h000001;

  function automatic void add(input string tag, input logic [5:0] op, input logic [5:0] fn,
                              input logic az, input logic mr, input logic [23:0] exp);
    vec_t v;
    v.tag = tag; v.op = op; v.fn = fn; v.az = az; v.mr = mr; v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [23:0] sample();
    return {bus.write_pc, bus.write_ir, bus.pc_src, bus.i_or_d, bus.mem_mode,
            bus.sign_ext, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
            bus.reg_dst, bus.mem_to_reg, bus.retire, bus.halted};
  endfunction

  task automatic compare(input string tag);
    logic [23:0] got;
    logic [23:0] exp;
    got = sample();
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %06h but scoreboard is empty", tag, got);
    end else begin
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL %s: got %06h expected %06h", tag, got, exp);
      end
    end
  endtask

  // One cycle: drive inputs on the falling edge, check mid-low-phase
  task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic az, input logic mr, input logic [23:0] exp);
    @(negedge clk);
    bus.opcode    = op;
    bus.func      = fn;
    bus.alu_zero  = az;
    bus.mem_ready = mr;
    sb.push_back(exp);
    #2;
    compare(tag);
  endtask

  task automatic check_now(input string tag, input logic [23:0] exp);
    sb.push_back(exp);
    compare(tag);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opcode = '0; bus.func = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;

    // ADDU, zero wait: 4 cycles
    add("idle",        6'h00, 6'h21, 1'b0, 1'b1, E_ZERO);
    add("addu.fetch",  6'h00, 6'h21, 1'b0, 1'b1, e_fetch(1'b1));
    add("addu.decode", 6'h00, 6'h21, 1'b0, 1'b0, e_decode());
    add("addu.exec",   6'h00, 6'h21, 1'b0, 1'b1, e_exec_r(2'd0, 4'd0));
    add("addu.wb",     6'h00, 6'h21, 1'b0, 1'b1, e_wb_r());
    // SUBU with one fetch wait state
    add("subu.fwait",  6'h00, 6'h23, 1'b0, 1'b0, e_fetch(1'b0));
    add("subu.fetch",  6'h00, 6'h23, 1'b0, 1'b1, e_fetch(1'b1));
    add("subu.decode", 6'h00, 6'h23, 1'b0, 1'b1, e_decode());
    add("subu.exec",   6'h00, 6'h23, 1'b0, 1'b1, e_exec_r(2'd0, 4'd1));
    add("subu.wb",     6'h00, 6'h23, 1'b0, 1'b1, e_wb_r());
    // Shifts use SA as operand A
    add("sll.fetch",   6'h00, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("sll.decode",  6'h00, 6'h00, 1'b0, 1'b1, e_decode());
    add("sll.exec",    6'h00, 6'h00, 1'b0, 1'b1, e_exec_r(2'd2, 4'd6));
    add("sll.wb",      6'h00, 6'h00, 1'b0, 1'b1, e_wb_r());
    add("sra.fetch",   6'h00, 6'h03, 1'b0, 1'b1, e_fetch(1'b1));
    add("sra.decode",  6'h00, 6'h03, 1'b0, 1'b1, e_decode());
    add("sra.exec",    6'h00, 6'h03, 1'b0, 1'b1, e_exec_r(2'd2, 4'd8));
    add("sra.wb",      6'h00, 6'h03, 1'b0, 1'b1, e_wb_r());
    add("sltu.fetch",  6'h00, 6'h2B, 1'b0, 1'b1, e_fetch(1'b1));
    add("sltu.decode", 6'h00, 6'h2B, 1'b0, 1'b1, e_decode());
    add("sltu.exec",   6'h00, 6'h2B, 1'b0, 1'b1, e_exec_r(2'd0, 4'd10));
    add("sltu.wb",     6'h00, 6'h2B, 1'b0, 1'b1, e_wb_r());
    // LW with 3 wait states in MEM_RD: 8 cycles
    add("lw.fetch",    6'h23, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("lw.decode",   6'h23, 6'h00, 1'b0, 1'b1, e_decode());
    add("lw.addr",     6'h23, 6'h00, 1'b0, 1'b1, e_mem_addr());
    add("lw.wait1",    6'h23, 6'h00, 1'b0, 1'b0, e_mem_rd());
    add("lw.wait2",    6'h23, 6'h00, 1'b0, 1'b0, e_mem_rd());
    add("lw.wait3",    6'h23, 6'h00, 1'b0, 1'b0, e_mem_rd());
    add("lw.rd",       6'h23, 6'h00, 1'b0, 1'b1, e_mem_rd());
    add("lw.wb",       6'h23, 6'h00, 1'b0, 1'b1, e_mem_wb());
    // SW with one write wait state
    add("sw.fetch",    6'h2B, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("sw.decode",   6'h2B, 6'h00, 1'b0, 1'b1, e_decode());
    add("sw.addr",     6'h2B, 6'h00, 1'b0, 1'b1, e_mem_addr());
    add("sw.wait",     6'h2B, 6'h00, 1'b0, 1'b0, e_mem_wr(1'b0));
    add("sw.wr",       6'h2B, 6'h00, 1'b0, 1'b1, e_mem_wr(1'b1));
    // BEQ taken, BNE not taken (alu_zero=1), BNE taken (alu_zero=0)
    add("beq.fetch",   6'h04, 6'h00, 1'b1, 1'b1, e_fetch(1'b1));
    add("beq.decode",  6'h04, 6'h00, 1'b1, 1'b1, e_decode());
    add("beq.branch",  6'h04, 6'h00, 1'b1, 1'b1, e_branch(1'b1));
    add("bne.fetch",   6'h05, 6'h00, 1'b1, 1'b1, e_fetch(1'b1));
    add("bne.decode",  6'h05, 6'h00, 1'b1, 1'b1, e_decode());
    add("bne.branch",  6'h05, 6'h00, 1'b1, 1'b1, e_branch(1'b0));
    add("bne0.fetch",  6'h05, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("bne0.decode", 6'h05, 6'h00, 1'b0, 1'b1, e_decode());
    add("bne0.branch", 6'h05, 6'h00, 1'b0, 1'b1, e_branch(1'b1));
    // JR: 3 cycles
    add("jr.fetch",    6'h00, 6'h08, 1'b0, 1'b1, e_fetch(1'b1));
    add("jr.decode",   6'h00, 6'h08, 1'b0, 1'b1, e_decode());
    add("jr.exec",     6'h00, 6'h08, 1'b0, 1'b1,
        mk(1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd12, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
    // I-type
    add("addiu.fetch", 6'h09, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("addiu.dec",   6'h09, 6'h00, 1'b0, 1'b1, e_decode());
    add("addiu.exec",  6'h09, 6'h00, 1'b0, 1'b1, e_exec_i(4'd0, 1'b1));
    add("addiu.wb",    6'h09, 6'h00, 1'b0, 1'b1, e_wb_i());
    add("slti.fetch",  6'h0A, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("slti.dec",    6'h0A, 6'h00, 1'b0, 1'b1, e_decode());
    add("slti.exec",   6'h0A, 6'h00, 1'b0, 1'b1, e_exec_i(4'd9, 1'b1));
    add("slti.wb",     6'h0A, 6'h00, 1'b0, 1'b1, e_wb_i());
    add("ori.fetch",   6'h0D, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("ori.dec",     6'h0D, 6'h00, 1'b0, 1'b1, e_decode());
    add("ori.exec",    6'h0D, 6'h00, 1'b0, 1'b1, e_exec_i(4'd3, 1'b0));
    add("ori.wb",      6'h0D, 6'h00, 1'b0, 1'b1, e_wb_i());
    add("lui.fetch",   6'h0F, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("lui.dec",     6'h0F, 6'h00, 1'b0, 1'b1, e_decode());
    add("lui.exec",    6'h0F, 6'h00, 1'b0, 1'b1, e_exec_i(4'd11, 1'b0));
    add("lui.wb",      6'h0F, 6'h00, 1'b0, 1'b1, e_wb_i());
    // J: 3 cycles; JAL: 4 cycles via LINK
    add("j.fetch",     6'h02, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("j.decode",    6'h02, 6'h00, 1'b0, 1'b1, e_decode());
    add("j.jump",      6'h02, 6'h00, 1'b0, 1'b1, e_jump(1'b1));
    add("jal.fetch",   6'h03, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("jal.decode",  6'h03, 6'h00, 1'b0, 1'b1, e_decode());
    add("jal.jump",    6'h03, 6'h00, 1'b0, 1'b1, e_jump(1'b0));
    add("jal.link",    6'h03, 6'h00, 1'b0, 1'b1, e_link());
    // Undecodable opcode
    add("bad.fetch",   6'h3F, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add("bad.decode",  6'h3F, 6'h00, 1'b0, 1'b1, e_decode());
    add("bad.trap",    6'h3F, 6'h00, 1'b0, 1'b1, E_TRAP);

    // Outputs are zero while held in reset
    #3;
    check_now("reset.held", E_ZERO);
    @(negedge clk);
    check_now("reset.held2", E_ZERO);
    release_reset();

    foreach (vecs[i])
      step(vecs[i].tag, vecs[i].op, vecs[i].fn, vecs[i].az, vecs[i].mr, vecs[i].exp);

    // TRAP is sticky for 10 cycles regardless of inputs
    for (int k = 0; k < 10; k++)
      step("trap.hold", 6'h00, 6'h21, k[0], k[1], E_TRAP);

    // Reset asserted mid-cycle clears TRAP immediately
    #1 rst_n = 1'b0;
    #1 check_now("trap.reset", E_ZERO);
    release_reset();

    // Illegal R-type funct traps from DECODE
    step("badfn.idle",   6'h00, 6'h01, 1'b0, 1'b1, E_ZERO);
    step("badfn.fetch",  6'h00, 6'h01, 1'b0, 1'b1, e_fetch(1'b1));
    step("badfn.decode", 6'h00, 6'h01, 1'b0, 1'b1, e_decode());
    step("badfn.trap",   6'h00, 6'h01, 1'b0, 1'b1, E_TRAP);
    step("badfn.hold",   6'h00, 6'h01, 1'b1, 1'b0, E_TRAP);

    #1 rst_n = 1'b0;
    #1 check_now("badfn.reset", E_ZERO);
    release_reset();

    // Reset asserted while waiting in MEM_RD, then a clean restart
    step("rst.idle",   6'h23, 6'h00, 1'b0, 1'b1, E_ZERO);
    step("rst.fetch",  6'h23, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    step("rst.decode", 6'h23, 6'h00, 1'b0, 1'b1, e_decode());
    step("rst.addr",   6'h23, 6'h00, 1'b0, 1'b1, e_mem_addr());
    step("rst.wait",   6'h23, 6'h00, 1'b0, 1'b0, e_mem_rd());
    #1 rst_n = 1'b0;
    #1 check_now("rst.midread", E_ZERO);
    @(negedge clk);
    check_now("rst.midread_held", E_ZERO);
    release_reset();
    step("rst2.idle",  6'h00, 6'h21, 1'b0, 1'b0, E_ZERO);
    step("rst2.fwait", 6'h00, 6'h21, 1'b0, 1'b0, e_fetch(1'b0));
    step("rst2.fetch", 6'h00, 6'h21, 1'b0, 1'b1, e_fetch(1'b1));
    step("rst2.dec",   6'h00, 6'h21, 1'b0, 1'b1, e_decode());

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard.drain: got %0d leftover entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
